// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
//   Multi-cycle bridge between the MIPS MEM stage and a 16-bit async SRAM.
//   Each 32-bit word access becomes two half-word SRAM phases (LO = bits
//   [15:0], HI = bits [31:16]). Each phase lasts WAIT_CYCLES+1 cycles. The
//   pipeline is frozen from the cycle the request is seen in IDLE until the
//   HI phase ends. A one-cycle DONE state then pulses ready and lets the
//   pipeline advance.
//
//   Optional feature, macro MEMSEQ_LASTWORD_EN:
//     Adds a one-entry last-word buffer. A read that hits a valid entry
//     completes in the request cycle with no SRAM activity and no freeze.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   mem_signals  {memRead, memWrite}; 2'b10 read, 2'b01 write, others no-op
//   addr         byte address; word index is addr[ADDR_W:2]
//   wdata        store data
//   rdata        load data, valid with ready after a read
//   ready        one-cycle completion pulse
//   freeze       pipeline stall
//   sram_addr    {word index, half}
//   sram_dq_in   SRAM read data
//   sram_dq_out  SRAM write data
//   sram_dq_oe   drive sram_dq_out onto the bus
//   sram_ce_n    chip enable (active-low)
//   sram_oe_n    output enable (active-low)
//   sram_we_n    write enable (active-low)
// ---------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_signals,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_dq_in,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  localparam int         WORD_W   = ADDR_W - 1;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q;
  logic [WORD_W-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              rd_req, wr_req, hit, start, phase_last;
  logic [31:0]       hit_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:ADDR_W+1], addr[1:0]};

  // Requests are gated by rst so that freeze stays low while reset is held.
  assign rd_req     = rst && (mem_signals == 2'b10);
  assign wr_req     = rst && (mem_signals == 2'b01);
  assign start      = (state_q == S_IDLE) && (rd_req || wr_req) && !hit;
  assign phase_last = (cnt_q == LAST_CNT);

`ifdef MEMSEQ_LASTWORD_EN
  logic              buf_vld_q;
  logic [WORD_W-1:0] buf_word_q;
  logic [31:0]       buf_data_q;

  assign hit      = (state_q == S_IDLE) && rd_req && buf_vld_q &&
                    (buf_word_q == addr[ADDR_W:2]);
  assign hit_data = buf_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld_q <= 1'b0;
    end else if ((state_q == S_DONE) && !op_wr_q) begin
      buf_vld_q <= 1'b1;
    end
  end

  // Completed reads refill the entry; completed writes keep a matching entry coherent.
  always_ff @(posedge clk) begin
    if (state_q == S_DONE) begin
      if (!op_wr_q) begin
        buf_word_q <= word_q;
        buf_data_q <= rdata_q;
      end else if (buf_vld_q && (buf_word_q == word_q)) begin
        buf_data_q <= wdata_q;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 32'h0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the wait counter clears on every phase change.
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'h0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LO;
      S_LO: begin
        if (phase_last) state_d = S_HI;
        else            cnt_d   = cnt_q + 4'h1;
      end
      S_HI: begin
        if (phase_last) state_d = S_DONE;
        else            cnt_d   = cnt_q + 4'h1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and read-data assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr_q <= 1'b0;
      word_q  <= '0;
      rdata_q <= 32'h0;
    end else begin
      if (start) begin
        op_wr_q <= wr_req;
        word_q  <= addr[ADDR_W:2];
      end
      if (hit) rdata_q <= hit_data;
      if (!op_wr_q && phase_last) begin
        if (state_q == S_LO) rdata_q[15:0]  <= sram_dq_in;
        if (state_q == S_HI) rdata_q[31:16] <= sram_dq_in;
      end
    end
  end

  // Store data only reaches the bus through the gated output mux below.
  always_ff @(posedge clk) begin
    if (start) wdata_q <= wdata;
  end

  // Output logic
  always_comb begin
    freeze      = start;
    ready       = hit;
    rdata       = hit ? hit_data : rdata_q;
    sram_addr   = {word_q, (state_q == S_HI)};
    sram_dq_out = 16'h0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    case (state_q)
      S_LO, S_HI: begin
        freeze    = 1'b1;
        sram_ce_n = 1'b0;
        if (op_wr_q) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
          // Last cycle of a write phase releases we_n to give data hold time.
          sram_we_n   = phase_last;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      S_DONE:  ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;
  localparam int W      = 2;
  localparam int ADDR_W = 18;
`ifdef MEMSEQ_LASTWORD_EN
  localparam bit LW = 1'b1;
`else
  localparam bit LW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        mem_signals = 2'b00;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       wdata = 32'h0;
  logic [31:0]       rdata;
  logic              ready, freeze;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_in, sram_dq_out;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  int checks   = 0;
  int failures = 0;

  mem_access_sequencer #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_signals(mem_signals), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .freeze(freeze), .sram_addr(sram_addr),
    .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- SRAM device model (256 half-words) ----------------
  logic [15:0] sram_mem [0:255];
  bit          sram_wv  [0:255];

  function automatic logic [15:0] sram_init(input int a);
    if (a == 8) return 16'hBEEF;
    if (a == 9) return 16'hDEAD;
    return 16'((a * 40503) ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] sram_rd(input logic [7:0] a);
    return sram_wv[a] ? sram_mem[a] : sram_init(int'(a));
  endfunction

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr[7:0]) : 16'h0;

  always @(posedge clk) begin
    if (rst && !sram_ce_n && !sram_we_n && sram_dq_oe) begin
      sram_mem[sram_addr[7:0]] <= sram_dq_out;
      sram_wv[sram_addr[7:0]]  <= 1'b1;
    end
  end

  // ---------------- Reference model (word level) ----------------
  logic [31:0] ref_mem [0:127];
  bit          ref_wv  [0:127];
  bit          m_busy, m_done, m_wr, bvalid;
  int          m_t;
  logic [16:0] m_word, bword;
  logic [31:0] m_wdata, m_rdata, bdata;

  function automatic logic [31:0] ref_rd(input logic [6:0] w);
    return ref_wv[w] ? ref_mem[w] : {sram_init(2 * int'(w) + 1), sram_init(2 * int'(w))};
  endfunction

  function automatic bit model_hit();
    return LW && (mem_signals == 2'b10) && bvalid && (bword == addr[18:2]);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_t = 0; m_wr = 0; bvalid = 0;
      m_word = '0; m_rdata = 32'h0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == 2 * (W + 1)) begin
        m_busy = 0;
        m_done = 1;
        if (m_wr) begin
          ref_mem[m_word[6:0]] = m_wdata;
          ref_wv[m_word[6:0]]  = 1'b1;
          if (bvalid && bword == m_word) bdata = m_wdata;
        end else begin
          m_rdata = ref_rd(m_word[6:0]);
          bvalid  = 1'b1;
          bword   = m_word;
          bdata   = m_rdata;
        end
      end
    end else if (model_hit()) begin
      m_rdata = bdata;
    end else if (mem_signals == 2'b10 || mem_signals == 2'b01) begin
      m_busy  = 1;
      m_t     = 0;
      m_wr    = (mem_signals == 2'b01);
      m_word  = addr[18:2];
      m_wdata = wdata;
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    int  sub;
    bit  hi, hitx, req;
    if (!rst) begin
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ready", ready, 0);
      chk("rst_freeze", freeze, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_dq_out", sram_dq_out, 0);
      chk("rst_dq_oe", sram_dq_oe, 0);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    end else if (m_busy) begin
      sub = m_t % (W + 1);
      hi  = (m_t >= W + 1);
      chk("phase_freeze", freeze, 1);
      chk("phase_ready", ready, 0);
      chk("phase_ce_n", sram_ce_n, 0);
      chk("phase_addr", sram_addr, {m_word, hi});
      if (m_wr) begin
        chk("wr_oe_n", sram_oe_n, 1);
        chk("wr_dq_oe", sram_dq_oe, 1);
        chk("wr_dq_out", sram_dq_out, hi ? m_wdata[31:16] : m_wdata[15:0]);
        chk("wr_we_n", sram_we_n, (sub == W));
      end else begin
        chk("rd_oe_n", sram_oe_n, 0);
        chk("rd_we_n", sram_we_n, 1);
        chk("rd_dq_oe", sram_dq_oe, 0);
      end
    end else if (m_done) begin
      chk("done_ready", ready, 1);
      chk("done_freeze", freeze, 0);
      chk("done_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      chk("done_rdata", rdata, m_rdata);
    end else begin
      hitx = model_hit();
      req  = (mem_signals == 2'b10 || mem_signals == 2'b01);
      chk("idle_freeze", freeze, req && !hitx);
      chk("idle_ready", ready, hitx);
      chk("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      chk("idle_rdata", rdata, hitx ? bdata : m_rdata);
    end
  end

  // ---------------- Directed access helper ----------------
  int          r_frz_first, r_frz_phase, r_ce, r_we, r_cycles;
  logic [31:0] r_rdata;
  logic [17:0] r_addr_first, r_addr_last;
  bit          r_timeout;

  // Called 1 time unit after a rising edge; returns at the same alignment.
  task automatic do_access(input logic [1:0] ms, input logic [31:0] a, input logic [31:0] wd);
    bit got_first;
    mem_signals = ms; addr = a; wdata = wd;
    r_frz_phase = 0; r_ce = 0; r_we = 0; r_cycles = 0; r_timeout = 1; got_first = 0;
    r_frz_first = 0; r_rdata = 32'h0; r_addr_first = '0; r_addr_last = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) r_frz_first = freeze;
      if (freeze && !sram_ce_n) r_frz_phase++;
      if (!sram_ce_n) begin
        r_ce++;
        if (!got_first) begin r_addr_first = sram_addr; got_first = 1; end
        r_addr_last = sram_addr;
      end
      if (!sram_we_n) r_we++;
      if (ready) begin
        r_rdata = rdata; r_cycles = i + 1; r_timeout = 0;
        break;
      end
    end
    chk("access_timeout", r_timeout, 0);
    @(posedge clk); #1;
    mem_signals = 2'b00;
  endtask

  // ---------------- Stimulus ----------------
  initial begin : stim
    int rdy_cnt;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) sram_wv[i] = 1'b0;
    for (int i = 0; i < 128; i++) ref_wv[i] = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ce_n", sram_ce_n, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: read 0x10 -> two 3-cycle phases, 0xDEADBEEF
    do_access(2'b10, 32'h0000_0010, 32'h0);
    chk("t1_freeze_req_cycle", r_frz_first, 1);
    chk("t1_freeze_phase_cycles", r_frz_phase, 6);
    chk("t1_cycles_to_ready", r_cycles, 8);
    chk("t1_rdata", r_rdata, 32'hDEADBEEF);
    chk("t1_addr_lo", r_addr_first, 18'h8);
    chk("t1_addr_hi", r_addr_last, 18'h9);

    // 2: write 0x12345678 to 0x20
    do_access(2'b01, 32'h0000_0020, 32'h1234_5678);
    chk("t2_addr_lo", r_addr_first, 18'h10);
    chk("t2_addr_hi", r_addr_last, 18'h11);
    chk("t2_we_cycles", r_we, 4);
    chk("t2_sram_lo", sram_rd(8'h10), 16'h5678);
    chk("t2_sram_hi", sram_rd(8'h11), 16'h1234);
    chk("t2_rdata_kept", r_rdata, 32'hDEADBEEF);

    // 3: write then read 0x40 back-to-back
    do_access(2'b01, 32'h0000_0040, 32'hCAFE_F00D);
    do_access(2'b10, 32'h0000_0040, 32'h0);
    chk("t3_read_ce_cycles", r_ce, 6);
    chk("t3_rdata", r_rdata, 32'hCAFEF00D);

    // 4: illegal 2'b11 for 5 cycles
    mem_signals = 2'b11; addr = 32'h0000_0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_freeze", freeze, 0);
      chk("t4_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
    end
    @(posedge clk); #1;
    mem_signals = 2'b00;

    // 5: reset during HI of a write to word 63
    mem_signals = 2'b01; addr = 32'h0000_00FC; wdata = 32'hA5A5_5A5A;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_in_hi_ce_n", sram_ce_n, 0);
    chk("t5_in_hi_addr", sram_addr, 18'h7F);
    rst = 1'b0;
    #1;
    chk("t5_abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
    chk("t5_abort_freeze", freeze, 0);
    mem_signals = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    chk("t5_no_ready_after_abort", rdy_cnt, 0);
    @(posedge clk); #1;

    // 6: read 0x10 twice
    do_access(2'b10, 32'h0000_0010, 32'h0);
    chk("t6_first_ce_cycles", r_ce, 6);
    do_access(2'b10, 32'h0000_0010, 32'h0);
    chk("t6_second_ce_cycles", r_ce, LW ? 0 : 6);
    chk("t6_second_freeze", r_frz_first, LW ? 0 : 1);
    chk("t6_second_cycles", r_cycles, LW ? 1 : 8);
    chk("t6_second_rdata", r_rdata, 32'hDEADBEEF);

    // Random traffic; inputs change freely, including while frozen.
    for (int i = 0; i < 500; i++) begin
      w = $urandom_range(99);
      mem_signals = (w < 40) ? 2'b00 : (w < 68) ? 2'b10 : (w < 92) ? 2'b01 : 2'b11;
      addr  = ($urandom() & 32'hFFF8_0000) | (32'($urandom_range(31)) << 2) | ($urandom() & 32'h3);
      wdata = $urandom();
      @(posedge clk); #1;
    end
    mem_signals = 2'b00;
    repeat (12) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
